imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Instruction-memory responder on the far end of the decoder fetch port (IREQ/IADDR -> INSTRUCTION).
//  Word-addressed RAM with a programmable read latency, fault flag for out-of-range fetches,
//  and a loader port that writes the program image between runs. Sits between the fetch/decode
//  stage and the testbench/boot loader in the RISC toy core.
// PARAMETERS
//  DEPTH   1024  number of 32-bit instruction words (power of 2); AW = $clog2(DEPTH)
//  RD_LAT  2     cycles from accepted request to IVALID; legal range 1..4
//  NOP     32'h0000_0000  word returned on fault (ADDI r0,r0,0)
// PORTS
//  CLK          in   1      clock, rising edge
//  RSTN         in   1      reset, asynchronous, active-low
//  IREQ         in   1      fetch request, sampled with IADDR
//  IADDR        in   30     word address [31:2] of instruction
//  IRDY         out  1      responder accepts IREQ this cycle
//  INSTRUCTION  out  32     fetched word, qualified by IVALID
//  IVALID       out  1      INSTRUCTION valid (one-cycle pulse per accepted request)
//  IFAULT       out  1      accompanies IVALID: address out of range, INSTRUCTION=NOP
//  LOAD_START   in   1      pulse: request entry to load mode
//  LOAD_DONE    in   1      pulse: leave load mode
//  LD_VALID     in   1      loader write strobe
//  LD_ADDR      in   30     loader word address
//  LD_DATA      in   32     loader word
//  LD_READY     out  1      high in LOAD state; write occurs on LD_VALID&&LD_READY
//  LD_ERR       out  1      sticky: out-of-range loader write dropped; cleared on LOAD_START accept
//  LD_COUNT     out  AW+1   words written in current load session (saturating at DEPTH)
// BEHAVIOUR
//  Reset: state=RUN, IRDY=1, IVALID=0, IFAULT=0, INSTRUCTION=NOP, LD_READY=0, LD_ERR=0,
//   LD_COUNT=0, read pipeline cleared; RAM contents NOT reset.
//  States: RUN -> (LOAD_START) DRAIN -> (pipeline empty) LOAD -> (LOAD_DONE) RUN.
//   RUN:   IRDY=1; one request accepted per cycle (full throughput, no bubbles).
//   DRAIN: IRDY=0; in-flight reads complete normally; moves to LOAD the cycle after last IVALID
//          (immediately next cycle if pipeline already empty).
//   LOAD:  IRDY=0, LD_READY=1; IREQ ignored (no response, no fault).
//  Accept = IREQ && IRDY. Response exactly RD_LAT cycles later: IVALID=1 with mem[IADDR] or,
//   if IADDR >= DEPTH (any bit above AW-1 set), IFAULT=1 and INSTRUCTION=NOP. Order preserved.
//  INSTRUCTION holds last value when IVALID=0.
//  LOAD_START in same cycle as an accepted IREQ: request is accepted, then DRAIN.
//  LOAD_START outside RUN: ignored. LOAD_DONE outside LOAD: ignored.
//  Loader write: in-range -> mem[LD_ADDR[AW-1:0]] <= LD_DATA, LD_COUNT+1 (saturate DEPTH);
//   out-of-range -> dropped, LD_ERR=1. LD_VALID with LOAD_DONE same cycle: write performed, then RUN.
//  Entering DRAIN clears LD_ERR and LD_COUNT.
//  RSTN low mid-read or mid-load: pipeline discarded (no IVALID after reset), state RUN;
//   RAM writes already completed persist.
//  First fetch after LOAD returns data written in that LOAD (write-then-read on consecutive cycles OK).
// STRUCTURE
//  risc_toy_pkg: NOP constant, opcode localparams shared with decoder, imem_state_t {RUN,DRAIN,LOAD}.
//  Sub-module imem_rd_pipe: RD_LAT-deep shift register of {valid,fault,data}, with 'empty' output
//   for DRAIN exit. Top holds RAM array, FSM, loader counters.
// TESTING
//  1 Load words 0..3 = 32'h1111_0000+i, LOAD_DONE; IREQ addr 0..3 back-to-back
//    -> IVALID 4 consecutive cycles starting RD_LAT after first accept, data in order.
//  2 IREQ IADDR=DEPTH (30'd1024) -> IVALID=1, IFAULT=1, INSTRUCTION=32'h0 after RD_LAT.
//  3 LOAD_START with 2 reads in flight -> IRDY=0 same+next cycles, both IVALIDs delivered,
//    LD_READY=1 cycle after last IVALID.
//  4 Loader write LD_ADDR=30'h3FFF_FFFF -> LD_ERR=1, LD_COUNT unchanged, RAM unchanged;
//    next LOAD_START clears LD_ERR.
//  5 LD_VALID+LOAD_DONE same cycle at addr 5 data 32'hDEAD_BEEF, IREQ addr 5 next cycle
//    -> INSTRUCTION=32'hDEAD_BEEF.
//  6 RSTN low while IVALID pending -> no IVALID after release, IRDY=1, earlier RAM contents readable.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder of the RISC toy core:
// the NOP encoding returned on faulted fetches, a few opcode values shared with
// the decoder, the responder state encoding and the address range helper.
package imem_responder_pkg;

  // ADDI r0,r0,0 encodes as all zeros in the toy ISA.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Major opcode field [31:26], shared with the decoder.
  localparam logic [5:0] OPC_ADDI   = 6'h00;
  localparam logic [5:0] OPC_ALU    = 6'h01;
  localparam logic [5:0] OPC_LOAD   = 6'h02;
  localparam logic [5:0] OPC_STORE  = 6'h03;
  localparam logic [5:0] OPC_BRANCH = 6'h04;
  localparam logic [5:0] OPC_JUMP   = 6'h05;

  // Responder operating modes.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } imem_state_t;

  // True when a 30-bit word address falls inside a memory of 'depth' words.
  // The full address is compared so upper bits can never alias into the array.
  function automatic logic addr_in_range(input logic [29:0] addr, input int unsigned depth);
    return ({2'b00, addr} < depth);
  endfunction

endpackage

// File: rtl/imem_responder_rd_pipe.sv
// Read-response pipeline of the instruction memory: an RD_LAT-deep shift
// register of {valid, fault, data}. The last stage drives the fetch response
// directly. Data registers only load behind a valid entry, so the output word
// holds its last delivered value while no response is present.
module imem_responder_rd_pipe
  import imem_responder_pkg::*;
#(
  parameter int          RD_LAT   = 2,
  parameter logic [31:0] RST_DATA = NOP_WORD
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        in_valid,
  input  logic        in_fault,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic        out_fault,
  output logic [31:0] out_data,
  output logic        empty
);

  logic [RD_LAT-1:0]       valid_q;
  logic [RD_LAT-1:0]       valid_d;
  logic [RD_LAT-1:0]       fault_q;
  logic [RD_LAT-1:0]       fault_d;
  logic [RD_LAT-1:0][31:0] data_q;
  logic [RD_LAT-1:0][31:0] data_d;
  logic                    empty_s;

  // Shift every stage forward one slot; data moves only behind a valid entry.
  always_comb begin
    valid_d    = valid_q;
    fault_d    = fault_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    fault_d[0] = in_valid & in_fault;
    if (in_valid) begin
      data_d[0] = in_data;
    end else begin
      data_d[0] = data_q[0];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      fault_d[i] = fault_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end else begin
        data_d[i] = data_q[i];
      end
    end
  end

  // Nothing queued behind the output stage: with no new push the pipe is idle
  // from the next cycle on, which is when DRAIN may hand over to LOAD.
  always_comb begin
    empty_s = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      empty_s = empty_s & ~valid_q[i];
    end
  end

  // Pipeline stage registers; reset discards every in-flight response.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= '0;
      fault_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_q[i] <= RST_DATA;
      end
    end else begin
      valid_q <= valid_d;
      fault_q <= fault_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_fault = fault_q[RD_LAT-1];
  assign out_data  = data_q[RD_LAT-1];
  assign empty     = empty_s;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the decoder fetch port. Holds the program
// RAM, the RUN/DRAIN/LOAD mode FSM and the loader bookkeeping; read responses
// travel through imem_responder_rd_pipe so they appear RD_LAT cycles after the
// accepting edge, in order, one per cycle.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          DEPTH  = 1024,
  parameter int          RD_LAT = 2,
  parameter logic [31:0] NOP    = NOP_WORD
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       IREQ,
  input  logic [29:0]                IADDR,
  output logic                       IRDY,
  output logic [31:0]                INSTRUCTION,
  output logic                       IVALID,
  output logic                       IFAULT,
  input  logic                       LOAD_START,
  input  logic                       LOAD_DONE,
  input  logic                       LD_VALID,
  input  logic [29:0]                LD_ADDR,
  input  logic [31:0]                LD_DATA,
  output logic                       LD_READY,
  output logic                       LD_ERR,
  output logic [$clog2(DEPTH):0]     LD_COUNT
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    COUNT_MAX = (AW+1)'(DEPTH);

  // Program storage; deliberately not reset so an image survives RSTN.
  logic [31:0] mem_q [DEPTH];

  imem_state_t state_q;
  imem_state_t state_d;
  logic        irdy_q;
  logic        irdy_d;
  logic        ld_ready_q;
  logic        ld_ready_d;
  logic        ld_err_q;
  logic        ld_err_d;
  logic [AW:0] ld_count_q;
  logic [AW:0] ld_count_d;

  logic        accept_s;
  logic        rd_fault_s;
  logic [31:0] rd_word_s;
  logic [31:0] rd_data_s;
  logic        pipe_empty_s;
  logic        enter_drain_s;
  logic        ld_strobe_s;
  logic        ld_in_range_s;
  logic        ld_we_s;

  // Fetch side: accept, range check and the word pushed into the pipeline.
  always_comb begin
    accept_s   = IREQ & irdy_q;
    rd_fault_s = ~addr_in_range(IADDR, DEPTH);
    rd_word_s  = mem_q[IADDR[AW-1:0]];
    if (rd_fault_s) begin
      rd_data_s = NOP;
    end else begin
      rd_data_s = rd_word_s;
    end
  end

  imem_responder_rd_pipe #(
    .RD_LAT   (RD_LAT),
    .RST_DATA (NOP)
  ) u_rd_pipe (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .in_valid  (accept_s),
    .in_fault  (rd_fault_s),
    .in_data   (rd_data_s),
    .out_valid (IVALID),
    .out_fault (IFAULT),
    .out_data  (INSTRUCTION),
    .empty     (pipe_empty_s)
  );

  // Mode register plus the registered handshake outputs derived from it.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_RUN;
      irdy_q     <= 1'b1;
      ld_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      irdy_q     <= irdy_d;
      ld_ready_q <= ld_ready_d;
    end
  end

  // Next mode: LOAD_START only counts in RUN, LOAD_DONE only in LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (LOAD_START) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        if (LOAD_DONE) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Handshake outputs for the coming cycle, decoded from the next mode.
  always_comb begin
    irdy_d     = 1'b0;
    ld_ready_d = 1'b0;
    case (state_d)
      ST_RUN: begin
        irdy_d     = 1'b1;
        ld_ready_d = 1'b0;
      end
      ST_DRAIN: begin
        irdy_d     = 1'b0;
        ld_ready_d = 1'b0;
      end
      ST_LOAD: begin
        irdy_d     = 1'b0;
        ld_ready_d = 1'b1;
      end
      default: begin
        irdy_d     = 1'b0;
        ld_ready_d = 1'b0;
      end
    endcase
  end

  // Loader bookkeeping: session cleared on entry to DRAIN, count saturates,
  // out-of-range writes are dropped and flagged.
  always_comb begin
    enter_drain_s = (state_q == ST_RUN) & LOAD_START;
    ld_strobe_s   = LD_VALID & ld_ready_q;
    ld_in_range_s = addr_in_range(LD_ADDR, DEPTH);
    ld_we_s       = ld_strobe_s & ld_in_range_s;
    ld_err_d      = ld_err_q;
    ld_count_d    = ld_count_q;
    if (enter_drain_s) begin
      ld_err_d   = 1'b0;
      ld_count_d = '0;
    end else if (ld_strobe_s) begin
      if (!ld_in_range_s) begin
        ld_err_d = 1'b1;
      end else if (ld_count_q != COUNT_MAX) begin
        ld_count_d = ld_count_q + 1'b1;
      end else begin
        ld_count_d = ld_count_q;
      end
    end else begin
      ld_err_d   = ld_err_q;
      ld_count_d = ld_count_q;
    end
  end

  // Loader status registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ld_err_q   <= 1'b0;
      ld_count_q <= '0;
    end else begin
      ld_err_q   <= ld_err_d;
      ld_count_q <= ld_count_d;
    end
  end

  // Program RAM write port, driven only by accepted in-range loader writes.
  always_ff @(posedge CLK) begin
    if (ld_we_s) begin
      mem_q[LD_ADDR[AW-1:0]] <= LD_DATA;
    end
  end

  assign IRDY     = irdy_q;
  assign LD_READY = ld_ready_q;
  assign LD_ERR   = ld_err_q;
  assign LD_COUNT = ld_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a table of fetch vectors streamed
// back-to-back plus hand-written sequences for drain, loader errors,
// write-then-read and reset during an in-flight read.
module tb_imem_responder;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int AW     = 10;
  localparam int NV     = 9;

  logic          CLK;
  logic          RSTN;
  logic          IREQ;
  logic [29:0]   IADDR;
  logic          IRDY;
  logic [31:0]   INSTRUCTION;
  logic          IVALID;
  logic          IFAULT;
  logic          LOAD_START;
  logic          LOAD_DONE;
  logic          LD_VALID;
  logic [29:0]   LD_ADDR;
  logic [31:0]   LD_DATA;
  logic          LD_READY;
  logic          LD_ERR;
  logic [AW:0]   LD_COUNT;

  typedef struct {
    logic [29:0] addr;
    logic        fault;
    logic [31:0] data;
  } rd_vec_t;

  rd_vec_t vecs [NV];
  int      n_checks = 0;
  int      n_fail   = 0;

  imem_responder #(
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .NOP    (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .IREQ        (IREQ),
    .IADDR       (IADDR),
    .IRDY        (IRDY),
    .INSTRUCTION (INSTRUCTION),
    .IVALID      (IVALID),
    .IFAULT      (IFAULT),
    .LOAD_START  (LOAD_START),
    .LOAD_DONE   (LOAD_DONE),
    .LD_VALID    (LD_VALID),
    .LD_ADDR     (LD_ADDR),
    .LD_DATA     (LD_DATA),
    .LD_READY    (LD_READY),
    .LD_ERR      (LD_ERR),
    .LD_COUNT    (LD_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic enter_load();
    int waited;
    LOAD_START = 1'b1;
    step();
    LOAD_START = 1'b0;
    waited = 0;
    while (LD_READY !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    check("load_entry", {31'd0, LD_READY}, 32'd1);
  endtask

  task automatic ld_write(input logic [29:0] a, input logic [31:0] d);
    LD_VALID = 1'b1;
    LD_ADDR  = a;
    LD_DATA  = d;
    step();
    LD_VALID = 1'b0;
  endtask

  task automatic load_done();
    LOAD_DONE = 1'b1;
    step();
    LOAD_DONE = 1'b0;
  endtask

  task automatic read_word(input string name, input logic [29:0] a, input logic [31:0] exp);
    IREQ  = 1'b1;
    IADDR = a;
    step();
    IREQ = 1'b0;
    repeat (RD_LAT - 1) step();
    check({name, "_valid"}, {31'd0, IVALID}, 32'd1);
    check({name, "_fault"}, {31'd0, IFAULT}, 32'd0);
    check({name, "_data"}, INSTRUCTION, exp);
  endtask

  initial begin
    int seen;
    vecs[0] = '{addr: 30'd0,           fault: 1'b0, data: 32'h1111_0000};
    vecs[1] = '{addr: 30'd1,           fault: 1'b0, data: 32'h1111_0001};
    vecs[2] = '{addr: 30'd2,           fault: 1'b0, data: 32'h1111_0002};
    vecs[3] = '{addr: 30'd3,           fault: 1'b0, data: 32'h1111_0003};
    vecs[4] = '{addr: 30'd1024,        fault: 1'b1, data: 32'h0000_0000};
    vecs[5] = '{addr: 30'd1023,        fault: 1'b0, data: 32'hCAFE_03FF};
    vecs[6] = '{addr: 30'h3FFF_FFFF,   fault: 1'b1, data: 32'h0000_0000};
    vecs[7] = '{addr: 30'd10,          fault: 1'b0, data: 32'hA5A5_0010};
    vecs[8] = '{addr: 30'd2049,        fault: 1'b1, data: 32'h0000_0000};

    RSTN       = 1'b0;
    IREQ       = 1'b0;
    IADDR      = 30'd0;
    LOAD_START = 1'b0;
    LOAD_DONE  = 1'b0;
    LD_VALID   = 1'b0;
    LD_ADDR    = 30'd0;
    LD_DATA    = 32'd0;
    repeat (2) step();
    RSTN = 1'b1;
    step();

    // Reset state
    check("rst_irdy",     {31'd0, IRDY},     32'd1);
    check("rst_ivalid",   {31'd0, IVALID},   32'd0);
    check("rst_ifault",   {31'd0, IFAULT},   32'd0);
    check("rst_instr",    INSTRUCTION,       32'h0000_0000);
    check("rst_ld_ready", {31'd0, LD_READY}, 32'd0);
    check("rst_ld_err",   {31'd0, LD_ERR},   32'd0);
    check("rst_ld_count", {21'd0, LD_COUNT}, 32'd0);

    // Load image, then stream the read table back-to-back
    enter_load();
    check("ld1_irdy", {31'd0, IRDY}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ld_write(30'(i), 32'h1111_0000 + 32'(i));
    end
    ld_write(30'd1023, 32'hCAFE_03FF);
    ld_write(30'd10,   32'hA5A5_0010);
    check("ld1_count", {21'd0, LD_COUNT}, 32'd6);
    check("ld1_err",   {31'd0, LD_ERR},   32'd0);
    load_done();
    check("ld1_done_irdy",     {31'd0, IRDY},     32'd1);
    check("ld1_done_ld_ready", {31'd0, LD_READY}, 32'd0);

    for (int j = 0; j < NV + RD_LAT; j++) begin
      if (j >= RD_LAT) begin
        check($sformatf("rd%0d_valid", j - RD_LAT), {31'd0, IVALID}, 32'd1);
        check($sformatf("rd%0d_fault", j - RD_LAT), {31'd0, IFAULT}, {31'd0, vecs[j-RD_LAT].fault});
        check($sformatf("rd%0d_data",  j - RD_LAT), INSTRUCTION, vecs[j-RD_LAT].data);
      end else begin
        check($sformatf("rd_lead%0d_valid", j), {31'd0, IVALID}, 32'd0);
      end
      if (j < NV) begin
        IREQ  = 1'b1;
        IADDR = vecs[j].addr;
      end else begin
        IREQ = 1'b0;
      end
      step();
    end
    check("hold_valid", {31'd0, IVALID}, 32'd0);
    check("hold_fault", {31'd0, IFAULT}, 32'd0);
    check("hold_data",  INSTRUCTION,     32'h0000_0000);
    read_word("hold_prep", 30'd1, 32'h1111_0001);
    step();
    check("hold2_valid", {31'd0, IVALID}, 32'd0);
    check("hold2_data",  INSTRUCTION,     32'h1111_0001);

    // LOAD_START with two reads in flight
    IREQ  = 1'b1;
    IADDR = 30'd2;
    step();
    IADDR      = 30'd3;
    LOAD_START = 1'b1;
    step();
    LOAD_START = 1'b0;
    IADDR      = 30'd0;
    check("drn_a_irdy",     {31'd0, IRDY},     32'd0);
    check("drn_a_valid",    {31'd0, IVALID},   32'd1);
    check("drn_a_data",     INSTRUCTION,       32'h1111_0002);
    check("drn_a_ld_ready", {31'd0, LD_READY}, 32'd0);
    step();
    check("drn_b_irdy",     {31'd0, IRDY},     32'd0);
    check("drn_b_valid",    {31'd0, IVALID},   32'd1);
    check("drn_b_data",     INSTRUCTION,       32'h1111_0003);
    check("drn_b_ld_ready", {31'd0, LD_READY}, 32'd0);
    step();
    check("drn_c_valid",    {31'd0, IVALID},   32'd0);
    check("drn_c_ld_ready", {31'd0, LD_READY}, 32'd1);
    check("drn_c_irdy",     {31'd0, IRDY},     32'd0);
    repeat (3) step();
    check("load_ignore_valid", {31'd0, IVALID}, 32'd0);
    check("load_ignore_fault", {31'd0, IFAULT}, 32'd0);
    IREQ = 1'b0;

    // Out-of-range loader write is dropped and flagged
    check("ld2_count0", {21'd0, LD_COUNT}, 32'd0);
    ld_write(30'h3FFF_FFFF, 32'hBAD0_BAD0);
    check("ld2_err",    {31'd0, LD_ERR},   32'd1);
    check("ld2_count1", {21'd0, LD_COUNT}, 32'd0);
    ld_write(30'd7, 32'h7777_0007);
    check("ld2_err_sticky", {31'd0, LD_ERR},   32'd1);
    check("ld2_count2",     {21'd0, LD_COUNT}, 32'd1);

    // Final write together with LOAD_DONE, fetch it on the next cycle
    LD_VALID  = 1'b1;
    LD_ADDR   = 30'd5;
    LD_DATA   = 32'hDEAD_BEEF;
    LOAD_DONE = 1'b1;
    step();
    LD_VALID  = 1'b0;
    LOAD_DONE = 1'b0;
    check("wd_irdy",     {31'd0, IRDY},     32'd1);
    check("wd_ld_ready", {31'd0, LD_READY}, 32'd0);
    check("wd_count",    {21'd0, LD_COUNT}, 32'd2);
    IREQ  = 1'b1;
    IADDR = 30'd5;
    step();
    IADDR = 30'd1023;
    step();
    check("wd_rd5_valid", {31'd0, IVALID}, 32'd1);
    check("wd_rd5_data",  INSTRUCTION,     32'hDEAD_BEEF);
    IADDR = 30'd7;
    step();
    check("wd_rd1023_data", INSTRUCTION, 32'hCAFE_03FF);
    IREQ = 1'b0;
    step();
    check("wd_rd7_data", INSTRUCTION, 32'h7777_0007);

    // Next load session clears the sticky error and the count
    enter_load();
    check("ld3_err",   {31'd0, LD_ERR},   32'd0);
    check("ld3_count", {21'd0, LD_COUNT}, 32'd0);
    load_done();

    // Reset while a read is in flight
    IREQ  = 1'b1;
    IADDR = 30'd0;
    step();
    IREQ = 1'b0;
    RSTN = 1'b0;
    #1;
    check("arst_valid", {31'd0, IVALID}, 32'd0);
    check("arst_irdy",  {31'd0, IRDY},   32'd1);
    repeat (2) step();
    RSTN = 1'b1;
    seen = 0;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      step();
      if (IVALID === 1'b1) begin
        seen++;
      end else begin
        seen = seen;
      end
    end
    check("arst_no_valid", 32'(seen), 32'd0);
    check("arst_irdy_after", {31'd0, IRDY}, 32'd1);
    read_word("arst_rd3", 30'd3, 32'h1111_0003);
    read_word("arst_rd5", 30'd5, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
